// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the counter run controller: state encoding and default widths.
package crc_pkg;

    localparam int RUN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Control/status bundle between the run controller and its user (software wrapper + datapath).
interface counter_run_ctrl_if
    import crc_pkg::*;
#(
    parameter int RUN_W = RUN_W_DEF
);
    logic             start;
    logic             ack;
    logic             clr_status;
    logic             dp_done;
    logic             en;
    logic             clear;
    logic             busy;
    logic             complete;
    logic [RUN_W-1:0] run_count;
    logic             overrun;
    logic             timeout;

    modport master (
        output start, ack, clr_status, dp_done,
        input  en, clear, busy, complete, run_count, overrun, timeout
    );

    modport slave (
        input  start, ack, clr_status, dp_done,
        output en, clear, busy, complete, run_count, overrun, timeout
    );
endinterface

// File: rtl/counter_run_ctrl_sat_counter.sv
// Saturating up-counter; a synchronous clear beats a simultaneous increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run-control FSM for the counter datapath: start -> clear -> count -> hold-until-ack.
// Optional ack timeout in HOLD is enabled with `define CRC_ACK_TIMEOUT_EN.
module counter_run_ctrl
    import crc_pkg::*;
#(
    parameter int RUN_W       = RUN_W_DEF,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_run_ctrl_if.slave  bus
);

    if (ACK_TIMEOUT < 2) begin : g_bad_timeout
        $error("counter_run_ctrl: ACK_TIMEOUT must be >= 2");
    end

    state_t state, nxt;
    logic   run_done;
    logic   wait_hit;
    logic   in_hold;

    assign in_hold = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        run_done = 1'b0;
        case (state)
            IDLE:  if (bus.start) nxt = CLEAR;
            CLEAR: nxt = COUNT;
            COUNT: if (bus.dp_done) nxt = HOLD;
            HOLD: begin
                // ack outranks the timeout when both land in the same cycle
                if (bus.ack) begin
                    nxt      = IDLE;
                    run_done = 1'b1;
                end else if (wait_hit) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.en       = (state == COUNT);
    assign bus.clear    = (state == CLEAR);
    assign bus.busy     = (state != IDLE);
    assign bus.complete = in_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.overrun <= 1'b0;
        else if (bus.clr_status)
            bus.overrun <= 1'b0;
        else if (bus.start && (state != IDLE))
            bus.overrun <= 1'b1;
    end

    sat_counter #(.W(RUN_W)) u_runs (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run_done),
        .clr   (bus.clr_status),
        .q     (bus.run_count)
    );

`ifdef CRC_ACK_TIMEOUT_EN
    localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

    logic [WC_W-1:0] wcnt;

    // Held at zero outside HOLD so every HOLD entry starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wcnt <= '0;
        else if (!in_hold)
            wcnt <= '0;
        else if (!bus.ack)
            wcnt <= wcnt + 1'b1;
    end

    assign wait_hit = in_hold && !bus.ack && (wcnt == WC_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.timeout <= 1'b0;
        else if (bus.clr_status)
            bus.timeout <= 1'b0;
        else if (wait_hit)
            bus.timeout <= 1'b1;
    end
`else
    assign wait_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

endmodule
